// File: rtl/mem_req_port.sv
// mem_req_port: initiator side of the CPU memory req/resp interface.
// Turns one byte-addressed load/store command into a word request with a
// byte write mask and lane-replicated data, then waits for the single
// outstanding read and returns the extracted, sign/zero-extended value.
// Optional feature macro: MEM_REQ_PORT_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word commands complete with an error and issue no request.
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 16
`endif

module mem_req_port #(
  parameter int unsigned CPU_WIDTH      = 32,
  parameter int unsigned ADDR_BITS      = `CPU_ADDR_BITS,
  parameter int unsigned WORD_ADDR_BITS = ADDR_BITS - 2,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_BITS-1:0]      cmd_addr,
  input  logic [CPU_WIDTH-1:0]      cmd_wdata,
  input  logic                      cmd_store,
  input  logic [1:0]                cmd_size,
  input  logic                      cmd_unsigned,
  output logic                      done_valid,
  output logic [CPU_WIDTH-1:0]      done_rdata,
  output logic                      done_err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_data,
  output logic [3:0]                mem_req_write,
  input  logic                      mem_resp_valid,
  input  logic [CPU_WIDTH-1:0]      mem_resp_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t                    state_q;
  logic                      cmd_ready_q;
  logic                      done_valid_q;
  logic                      done_err_q;
  logic [CPU_WIDTH-1:0]      done_rdata_q;
  logic                      req_valid_q;
  logic [WORD_ADDR_BITS-1:0] req_addr_q;
  logic [CPU_WIDTH-1:0]      req_data_q;
  logic [3:0]                req_write_q;
  logic                      store_q;
  logic [1:0]                size_q;
  logic                      uns_q;
  logic [1:0]                lane_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [3:0]                mask_d;
  logic [CPU_WIDTH-1:0]      wdata_d;
  logic [1:0]                lane_d;
  logic                      misalign_d;
  logic [CPU_WIDTH-1:0]      shifted_d;
  logic [CPU_WIDTH-1:0]      rdata_d;

  // Decode the offered command: byte mask, replicated store data, load lane.
  always_comb begin
    mask_d  = 4'b1111;
    wdata_d = cmd_wdata;
    lane_d  = 2'b00;
    case (cmd_size)
      2'd0: begin
        mask_d  = 4'b0001 << cmd_addr[1:0];
        wdata_d = {4{cmd_wdata[7:0]}};
        lane_d  = cmd_addr[1:0];
      end
      2'd1: begin
        mask_d  = 4'b0011 << {cmd_addr[1], 1'b0};
        wdata_d = {2{cmd_wdata[15:0]}};
        lane_d  = {cmd_addr[1], 1'b0};
      end
      default: begin
        mask_d  = 4'b1111;
        wdata_d = cmd_wdata;
        lane_d  = 2'b00;
      end
    endcase
`ifdef MEM_REQ_PORT_MISALIGN_TRAP_EN
    misalign_d = ((cmd_size == 2'd1) && cmd_addr[0]) ||
                 (cmd_size[1] && (cmd_addr[1:0] != 2'b00));
`else
    misalign_d = 1'b0;
`endif
  end

  // Extract and extend the load result from the returned word.
  always_comb begin
    shifted_d = mem_resp_data >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    rdata_d = uns_q ? {24'b0, shifted_d[7:0]}
                               : {{24{shifted_d[7]}}, shifted_d[7:0]};
      2'd1:    rdata_d = uns_q ? {16'b0, shifted_d[15:0]}
                               : {{16{shifted_d[15]}}, shifted_d[15:0]};
      default: rdata_d = shifted_d;
    endcase
  end

  // Command FSM with registered request and completion outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_rdata_q <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_write_q  <= '0;
      store_q      <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      cnt_q        <= '0;
    end else begin
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            store_q <= cmd_store;
            size_q  <= cmd_size;
            uns_q   <= cmd_unsigned;
            lane_q  <= lane_d;
            if (misalign_d) begin
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              cmd_ready_q <= 1'b0;
              req_valid_q <= 1'b1;
              req_addr_q  <= cmd_addr[ADDR_BITS-1:2];
              req_data_q  <= wdata_d;
              req_write_q <= cmd_store ? mask_d : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (store_q) begin
              state_q      <= S_IDLE;
              cmd_ready_q  <= 1'b1;
              done_valid_q <= 1'b1;
            end else begin
              state_q <= S_RESP;
              cnt_q   <= '0;
            end
          end
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            done_valid_q <= 1'b1;
            done_rdata_q <= rdata_d;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign done_valid    = done_valid_q;
  assign done_err      = done_err_q;
  assign done_rdata    = done_rdata_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_data_q;
  assign mem_req_write = req_write_q;

endmodule
